// File: rtl/watch_pkg.sv
// Shared types, 7-segment patterns, keypad decode and digit limits for the keypad clock.
package watch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_RUN
  } entry_state_t;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high; index n holds the pattern for digit n.
  localparam logic [9:0][7:0] SEG_DIGITS = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;

  localparam bcd_t H_TEN_MAX    = 4'd2;
  localparam bcd_t H_ONE_MAX_20 = 4'd3;
  localparam bcd_t TEN_MAX      = 4'd5;
  localparam bcd_t ONE_MAX      = 4'd9;

  function automatic bcd_t key_to_digit(input logic [9:0] k);
    bcd_t d;
    d = '0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) d = 4'(i);
    end
    return d;
  endfunction

  function automatic logic [7:0] bcd_to_seg(input bcd_t d);
    return (d <= ONE_MAX) ? SEG_DIGITS[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexed display scanner: walks an active-low digit select and registers
// the segment pattern of the selected position alongside it.
module seg_scan
  import watch_pkg::*;
#(
  parameter int SCAN_DIV = 1,
  parameter int DIGITS   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0][7:0] pattern,
  output logic [7:0]      seg_data,
  output logic [7:0]      seg_com
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_cnt, div_nxt;
  logic [2:0]    idx, idx_nxt;

  always_comb begin
    div_nxt = div_cnt + 1'b1;
    idx_nxt = idx;
    if (div_cnt == DW'(SCAN_DIV - 1)) begin
      div_nxt = '0;
      idx_nxt = (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
    end
  end

  // Select and data are registered from the same next index so they never skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      idx      <= '0;
      seg_com  <= 8'hFE;
      seg_data <= SEG_DASH;
    end else begin
      div_cnt  <= div_nxt;
      idx      <= idx_nxt;
      seg_com  <= ~(8'b1 << idx_nxt);
      seg_data <= pattern[idx_nxt];
    end
  end

endmodule

// File: rtl/keypad_clock.sv
// Keypad-set 24-hour BCD clock driving a multiplexed 7-segment display.
// Optional entry-digit blink is enabled by defining KEYPAD_CLOCK_BLINK_EN.
//
// state    | meaning
// ST_IDLE  | no time committed yet, display shows dashes
// ST_ENTRY | set_mode high, keys fill shadow digits left to right
// ST_RUN   | committed time advancing once per second
module keypad_clock
  import watch_pkg::*;
#(
  parameter int CLK_HZ   = 1000,
  parameter int SCAN_DIV = 1,
  parameter int DIGITS   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_mode,
  input  logic [9:0]  keypad,
  output logic [23:0] bcd_time,
  output logic        time_valid,
  output logic        sec_tick,
  output logic        entry_err,
  output logic [7:0]  seg_data,
  output logic [7:0]  seg_com
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  entry_state_t    state, state_nxt;
  logic [2:0]      pos, pos_nxt;
  bcd_t [5:0]      shadow, shadow_nxt, live, live_inc;
  logic [9:0]      key_prev;
  logic [PW-1:0]   presc;
  logic            key_evt, key_ok, commit, err_nxt, running, at_top, blink_off;
  bcd_t            key_d, lim;
  logic [7:0][7:0] pattern;

  assign key_evt  = $onehot(keypad) && (key_prev == '0);
  assign key_d    = key_to_digit(keypad);
  assign running  = (state == ST_RUN) && !set_mode && time_valid;
  assign at_top   = (presc == PW'(CLK_HZ - 1));
  assign bcd_time = {live[0], live[1], live[2], live[3], live[4], live[5]};

  always_comb begin
    case (pos)
      3'd0:       lim = H_TEN_MAX;
      3'd1:       lim = (shadow[0] == H_TEN_MAX) ? H_ONE_MAX_20 : ONE_MAX;
      3'd2, 3'd4: lim = TEN_MAX;
      default:    lim = ONE_MAX;
    endcase
    key_ok = (key_d <= lim);
  end

  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos;
    shadow_nxt = shadow;
    commit     = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (set_mode) begin
          state_nxt  = ST_ENTRY;
          pos_nxt    = '0;
          shadow_nxt = '0;
        end
      end
      ST_ENTRY: begin
        if (!set_mode) begin
          state_nxt  = time_valid ? ST_RUN : ST_IDLE;
          pos_nxt    = '0;
          shadow_nxt = '0;
        end else if (key_evt && pos < 3'd6) begin
          if (key_ok) begin
            shadow_nxt[pos] = key_d;
            pos_nxt         = pos + 1'b1;
            commit          = (pos == 3'd5);
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ripple BCD carry through seconds, minutes, then the 24-hour wrap.
  always_comb begin
    live_inc = live;
    if (live[5] != ONE_MAX) live_inc[5] = live[5] + 1'b1;
    else begin
      live_inc[5] = '0;
      if (live[4] != TEN_MAX) live_inc[4] = live[4] + 1'b1;
      else begin
        live_inc[4] = '0;
        if (live[3] != ONE_MAX) live_inc[3] = live[3] + 1'b1;
        else begin
          live_inc[3] = '0;
          if (live[2] != TEN_MAX) live_inc[2] = live[2] + 1'b1;
          else begin
            live_inc[2] = '0;
            if (live[0] == H_TEN_MAX && live[1] == H_ONE_MAX_20) live_inc[1:0] = '0;
            else if (live[1] == ONE_MAX) begin
              live_inc[1] = '0;
              live_inc[0] = live[0] + 1'b1;
            end else live_inc[1] = live[1] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pos        <= '0;
      shadow     <= '0;
      live       <= '0;
      presc      <= '0;
      key_prev   <= '0;
      time_valid <= 1'b0;
      sec_tick   <= 1'b0;
      entry_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      shadow    <= shadow_nxt;
      key_prev  <= keypad;
      entry_err <= err_nxt;
      sec_tick  <= running && at_top;
      if (commit) begin
        live       <= shadow_nxt;
        time_valid <= 1'b1;
        presc      <= '0;
      end else if (running) begin
        if (at_top) begin
          presc <= '0;
          live  <= live_inc;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

`ifdef KEYPAD_CLOCK_BLINK_EN
  localparam int BLINK_HALF = (CLK_HZ >= 4) ? CLK_HZ / 2 : 2;
  localparam int BLINK_OFF  = (CLK_HZ >= 4) ? CLK_HZ / 4 : 1;
  localparam int BW         = $clog2(BLINK_HALF);

  logic [BW-1:0] blink_cnt;

  // Down-counter restarts on each key so the next digit is shown before it blanks.
  always_ff @(posedge clk) begin
    if (rst || key_evt || blink_cnt == '0) blink_cnt <= BW'(BLINK_HALF - 1);
    else                                   blink_cnt <= blink_cnt - 1'b1;
  end
  assign blink_off = (blink_cnt < BW'(BLINK_OFF));
`else
  assign blink_off = 1'b0;
`endif

  always_comb begin
    pattern = '0;
    for (int i = 0; i < 6; i++) begin
      if (state == ST_ENTRY)
        pattern[i] = (3'(i) < pos)
                     ? (bcd_to_seg(shadow[i]) | ((i == 1 || i == 3) ? SEG_DP : SEG_BLANK))
                     : SEG_DASH;
      else if (!time_valid)
        pattern[i] = SEG_DASH;
      else
        pattern[i] = bcd_to_seg(live[i]) | ((i == 1 || i == 3) ? SEG_DP : SEG_BLANK);
    end
    if (state == ST_ENTRY && pos < 3'd6 && blink_off) pattern[pos] = SEG_BLANK;
  end

  seg_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DIGITS   (DIGITS)
  ) u_seg_scan (
    .clk      (clk),
    .rst      (rst),
    .pattern  (pattern),
    .seg_data (seg_data),
    .seg_com  (seg_com)
  );

endmodule

// File: tb/tb_keypad_clock.sv
// Directed self-checking bench for keypad_clock (CLK_HZ=50, SCAN_DIV=2, DIGITS=6).
module tb_keypad_clock;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_mode = 1'b0;
  logic [9:0]  keypad = '0;
  logic [23:0] bcd_time;
  logic        time_valid, sec_tick, entry_err;
  logic [7:0]  seg_data, seg_com;

  int errors = 0;
  int checks = 0;

  keypad_clock #(.CLK_HZ(50), .SCAN_DIV(2), .DIGITS(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .set_mode   (set_mode),
    .keypad     (keypad),
    .bcd_time   (bcd_time),
    .time_valid (time_valid),
    .sec_tick   (sec_tick),
    .entry_err  (entry_err),
    .seg_data   (seg_data),
    .seg_com    (seg_com)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int d, input logic err);
    keypad = 10'(1 << d);
    step(1);
    chk("entry_err", {31'b0, entry_err}, {31'b0, err});
    keypad = '0;
    step(1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_time"}, {8'b0, bcd_time}, 32'h0);
    chk({tag, "_valid"}, {31'b0, time_valid}, 32'h0);
    chk({tag, "_tick"}, {31'b0, sec_tick}, 32'h0);
    chk({tag, "_err"}, {31'b0, entry_err}, 32'h0);
    chk({tag, "_com"}, {24'b0, seg_com}, 32'hFE);
    chk({tag, "_data"}, {24'b0, seg_data}, 32'h40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_com;
    logic [7:0] exp_seg [6];
    int ticks;
    int w;

    // Reset values
    step(2);
    chk_reset_vals("reset");

    // Scan sequence, two cycles per digit, wrapping after six
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      exp_com = ~(8'b1 << (((k + 1) / 2) % 6));
      chk("scan_com", {24'b0, seg_com}, {24'b0, exp_com});
    end
    chk("idle_dash", {24'b0, seg_data}, 32'h40);

    // Non-one-hot and held keys, then abandon a partial entry
    set_mode = 1'b1;
    step(1);
    keypad = 10'h003; step(2);
    keypad = '0;      step(1);
    keypad = 10'h002; step(3);
    keypad = '0;      step(1);
    press(2, 1'b0);
    set_mode = 1'b0;
    step(2);
    chk("abandon_valid", {31'b0, time_valid}, 32'h0);
    chk("abandon_time", {8'b0, bcd_time}, 32'h0);
    step(3);
    chk("abandon_dash", {24'b0, seg_data}, 32'h40);

    // Full entry 12:34:56 with a glitch and a held key mixed in
    set_mode = 1'b1;
    step(1);
    keypad = 10'h003; step(1);
    keypad = '0;      step(1);
    keypad = 10'h002; step(3);
    keypad = '0;      step(1);
    press(2, 1'b0);
    press(3, 1'b0);
    press(4, 1'b0);
    press(5, 1'b0);
    press(6, 1'b0);
    chk("commit_time", {8'b0, bcd_time}, 32'h123456);
    chk("commit_valid", {31'b0, time_valid}, 32'h1);
    step(60);
    chk("frozen_entry", {8'b0, bcd_time}, 32'h123456);
    set_mode = 1'b0;
    step(50);
    chk("pre_tick_time", {8'b0, bcd_time}, 32'h123456);
    chk("pre_tick", {31'b0, sec_tick}, 32'h0);
    step(1);
    chk("tick_time", {8'b0, bcd_time}, 32'h123457);
    chk("tick_pulse", {31'b0, sec_tick}, 32'h1);
    step(1);
    chk("tick_end", {31'b0, sec_tick}, 32'h0);

    // Display of 12:34:57 with dp on h_one and m_one
    exp_seg = '{8'h06, 8'hDB, 8'h4F, 8'hE6, 8'h6D, 8'h07};
    for (int p = 0; p < 6; p++) begin
      exp_com = ~(8'b1 << p);
      w = 0;
      while (seg_com !== exp_com && w < 20) begin
        step(1);
        w++;
      end
      chk("disp_com", {24'b0, seg_com}, {24'b0, exp_com});
      chk("disp_seg", {24'b0, seg_data}, {24'b0, exp_seg[p]});
    end

    // Rejected h_one=4 after h_ten=2, then 23:59:59
    set_mode = 1'b1;
    step(1);
    press(2, 1'b0);
    press(4, 1'b1);
    press(3, 1'b0);
    chk("entry_live_frozen", {8'b0, bcd_time}, 32'h123457);
    press(5, 1'b0);
    press(9, 1'b0);
    press(5, 1'b0);
    press(9, 1'b0);
    chk("commit_2359", {8'b0, bcd_time}, 32'h235959);

    // Midnight rollover with exactly one tick
    set_mode = 1'b0;
    ticks = 0;
    for (int k = 0; k < 55; k++) begin
      step(1);
      if (sec_tick) ticks++;
    end
    chk("midnight_time", {8'b0, bcd_time}, 32'h0);
    chk("midnight_ticks", ticks, 1);
    chk("midnight_valid", {31'b0, time_valid}, 32'h1);

    // Reset mid-entry overrides a simultaneous key
    set_mode = 1'b1;
    step(1);
    press(1, 1'b0);
    press(2, 1'b0);
    press(3, 1'b0);
    rst = 1'b1;
    set_mode = 1'b0;
    keypad = 10'h010;
    step(1);
    chk_reset_vals("midrst");
    keypad = '0;
    rst = 1'b0;
    step(3);
    chk("post_rst_valid", {31'b0, time_valid}, 32'h0);

    // Hour carry 09:59:59 -> 10:00:00
    set_mode = 1'b1;
    step(1);
    press(0, 1'b0);
    press(9, 1'b0);
    press(5, 1'b0);
    press(9, 1'b0);
    press(5, 1'b0);
    press(9, 1'b0);
    chk("commit_0959", {8'b0, bcd_time}, 32'h095959);
    set_mode = 1'b0;
    step(52);
    chk("hour_carry", {8'b0, bcd_time}, 32'h100000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
